// File: rtl/star_softmax_norm.sv
// Softmax normalisation stage: prob = exp / sum_exp as unsigned Q1.FRAC via a restoring divider.
// Optional STAR_NORM_ROUND_EN: one extra guard iteration and round half-up instead of truncation.
module star_softmax_norm #(
    parameter  int unsigned VEC_LEN = 16,
    parameter  int unsigned FRAC    = 16,
    localparam int unsigned IW      = $clog2(VEC_LEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_exp,
    input  logic [31:0]     in_sum_exp,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FRAC:0]   out_prob,
    output logic [IW-1:0]   out_idx,
    output logic            out_last,
    output logic            out_sat,
    output logic            out_div0,
    output logic            busy
);

    localparam int unsigned PW = FRAC + 1;
`ifdef STAR_NORM_ROUND_EN
    localparam int unsigned NITER = FRAC + 1;
`else
    localparam int unsigned NITER = FRAC;
`endif
    localparam int unsigned QW = NITER;
    localparam int unsigned CW = $clog2(NITER + 1);
    localparam logic [FRAC:0] PROB_ONE = {1'b1, {FRAC{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_OUT} state_t;

    state_t          r_state, w_state;
    logic [32:0]     r_rem, w_rem;
    logic [31:0]     r_div, w_div;
    logic [QW-1:0]   r_quo, w_quo;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [IW-1:0]   r_idx, w_idx;
    logic            r_out_valid, w_out_valid;
    logic [FRAC:0]   r_out_prob, w_out_prob;
    logic [IW-1:0]   r_out_idx, w_out_idx;
    logic            r_out_last, w_out_last;
    logic            r_out_sat, w_out_sat;
    logic            r_out_div0, w_out_div0;

    logic [32:0]     w_r2;
    logic            w_ge;
    logic [32:0]     w_rem_next;
    logic [QW-1:0]   w_quo_next;
    logic [FRAC:0]   w_res;

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_prob  = r_out_prob;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign out_sat   = r_out_sat;
    assign out_div0  = r_out_div0;

    // Next-state and datapath; the remainder stays below the divisor so the shift never overflows.
    always_comb begin
        w_state     = r_state;
        w_rem       = r_rem;
        w_div       = r_div;
        w_quo       = r_quo;
        w_cnt       = r_cnt;
        w_idx       = r_idx;
        w_out_valid = r_out_valid;
        w_out_prob  = r_out_prob;
        w_out_idx   = r_out_idx;
        w_out_last  = r_out_last;
        w_out_sat   = r_out_sat;
        w_out_div0  = r_out_div0;

        w_r2       = r_rem << 1;
        w_ge       = (w_r2 >= {1'b0, r_div});
        w_rem_next = w_ge ? (w_r2 - {1'b0, r_div}) : w_r2;
        w_quo_next = {r_quo[QW-2:0], w_ge};
`ifdef STAR_NORM_ROUND_EN
        // Q>>1 is below 2^FRAC, so adding the guard bit tops out at exactly 1.0.
        w_res = PW'(w_quo_next >> 1) + PW'(w_quo_next[0]);
`else
        w_res = PW'(w_quo_next);
`endif

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_out_idx  = r_idx;
                    w_out_last = (r_idx == IW'(VEC_LEN - 1));
                    w_out_sat  = 1'b0;
                    w_out_div0 = 1'b0;
                    if (in_sum_exp == 32'd0) begin
                        w_out_prob  = '0;
                        w_out_div0  = 1'b1;
                        w_out_valid = 1'b1;
                        w_state     = S_OUT;
                    end else if (in_exp == 32'd0) begin
                        w_out_prob  = '0;
                        w_out_valid = 1'b1;
                        w_state     = S_OUT;
                    end else if (in_exp >= in_sum_exp) begin
                        w_out_prob  = PROB_ONE;
                        w_out_sat   = (in_exp > in_sum_exp);
                        w_out_valid = 1'b1;
                        w_state     = S_OUT;
                    end else begin
                        w_rem   = {1'b0, in_exp};
                        w_div   = in_sum_exp;
                        w_quo   = '0;
                        w_cnt   = CW'(NITER);
                        w_state = S_DIV;
                    end
                end
            end
            S_DIV: begin
                w_rem = w_rem_next;
                w_quo = w_quo_next;
                w_cnt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_out_prob  = w_res;
                    w_out_valid = 1'b1;
                    w_state     = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_out_valid = 1'b0;
                    w_idx       = (r_idx == IW'(VEC_LEN - 1)) ? '0 : r_idx + IW'(1);
                    w_state     = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_div       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_prob  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_out_sat   <= 1'b0;
            r_out_div0  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_rem       <= w_rem;
            r_div       <= w_div;
            r_quo       <= w_quo;
            r_cnt       <= w_cnt;
            r_idx       <= w_idx;
            r_out_valid <= w_out_valid;
            r_out_prob  <= w_out_prob;
            r_out_idx   <= w_out_idx;
            r_out_last  <= w_out_last;
            r_out_sat   <= w_out_sat;
            r_out_div0  <= w_out_div0;
        end
    end

endmodule

// File: tb/tb_star_softmax_norm.sv
// Directed bench for star_softmax_norm (VEC_LEN=16, FRAC=16); honours STAR_NORM_ROUND_EN.
module tb_star_softmax_norm;

`ifdef STAR_NORM_ROUND_EN
    localparam int DIVLAT = 18;
    localparam int P23    = 43691;
`else
    localparam int DIVLAT = 17;
    localparam int P23    = 43690;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_exp = '0;
    logic [31:0] in_sum_exp = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [16:0] out_prob;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        out_sat;
    logic        out_div0;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    star_softmax_norm #(.VEC_LEN(16), .FRAC(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_exp     (in_exp),
        .in_sum_exp (in_sum_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_prob   (out_prob),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .out_sat    (out_sat),
        .out_div0   (out_div0),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Called at a negedge with the block idle; returns edges from accept to out_valid.
    task automatic send(input logic [31:0] e, input logic [31:0] s, output int lat);
        check("in_ready_before_send", 64'(in_ready), 64'd1);
        in_valid   = 1'b1;
        in_exp     = e;
        in_sum_exp = s;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_pair(input string tag, input logic [31:0] e, input logic [31:0] s,
                            input int prob, input int idx, input bit last,
                            input bit sat, input bit div0, input int explat);
        int lat;
        send(e, s, lat);
        check({tag, "_latency"}, 64'(lat), 64'(explat));
        check({tag, "_valid"},   64'(out_valid), 64'd1);
        check({tag, "_prob"},    64'(out_prob), 64'(prob));
        check({tag, "_idx"},     64'(out_idx), 64'(idx));
        check({tag, "_last"},    64'(out_last), 64'(last));
        check({tag, "_sat"},     64'(out_sat), 64'(sat));
        check({tag, "_div0"},    64'(out_div0), 64'(div0));
        @(negedge clk);
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_prob",  64'(out_prob), 64'd0);
        check("rst_idx",   64'(out_idx), 64'd0);
        check("rst_flags", 64'({out_last, out_sat, out_div0}), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Divide path and fast paths
        run_pair("div_1_4",  32'd1, 32'd4, 16384, 0, 1'b0, 1'b0, 1'b0, DIVLAT);
        run_pair("eq_3_3",   32'd3, 32'd3, 65536, 1, 1'b0, 1'b0, 1'b0, 1);
        run_pair("sat_5_3",  32'd5, 32'd3, 65536, 2, 1'b0, 1'b1, 1'b0, 1);
        run_pair("zero_0_7", 32'd0, 32'd7, 0,     3, 1'b0, 1'b0, 1'b0, 1);
        run_pair("div0_9_0", 32'd9, 32'd0, 0,     4, 1'b0, 1'b0, 1'b1, 1);

        // Reset during the divide of element 5
        in_valid   = 1'b1;
        in_exp     = 32'd1;
        in_sum_exp = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_busy",     64'(busy), 64'd1);
        check("mid_in_ready", 64'(in_ready), 64'd0);
        check("mid_idx",      64'(out_idx), 64'd5);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy",     64'(busy), 64'd0);
        check("mid_rst_valid",    64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);

        // Full row plus wrap
        for (int i = 0; i < 17; i++) begin
            run_pair($sformatf("stream%0d", i), 32'd1, 32'd16, 4096, i % 16,
                     (i == 15), 1'b0, 1'b0, DIVLAT);
        end

        // Rounding-sensitive quotient
        run_pair("div_2_3", 32'd2, 32'd3, P23, 1, 1'b0, 1'b0, 1'b0, DIVLAT);

        // Back-pressure with a competing input that must be ignored
        out_ready = 1'b0;
        send(32'd7, 32'd10, lat);
        check("bp_latency", 64'(lat), 64'(DIVLAT));
        in_valid   = 1'b1;
        in_exp     = 32'd1;
        in_sum_exp = 32'd2;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid",    64'(out_valid), 64'd1);
            check("bp_prob",     64'(out_prob), 64'd45875);
            check("bp_idx",      64'(out_idx), 64'd2);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_busy",     64'(busy), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid",    64'(out_valid), 64'd0);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);

        // Index continues after the held element
        run_pair("after_bp", 32'd3, 32'd3, 65536, 3, 1'b0, 1'b0, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
